// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM encoding, timing defaults, command codes.
// Latency: n/a (types, constants and a pure frame-building function only).
// Backpressure: n/a.
package ps2_pkg;

  // Transmitter FSM encoding, 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_REQ   = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_ACKW  = 3'd6
  } ps2_state_t;

  // Default timing at a 50 MHz core clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us clock inhibit
  localparam int DEF_FILTER_LEN     = 8;       // debounce depth
  localparam int DEF_TIMEOUT_CYCLES = 100000;  // 2 ms between device clock edges

  // Counter widths sized for the default timing.
  localparam int INH_W  = 13;
  localparam int TO_W   = 17;
  localparam int EDGE_W = 4;

  // Common keyboard commands.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_SCAN_SET = 8'hF0;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Frame as shifted out LSB first: data bits, then odd parity.
  function automatic logic [8:0] ps2_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronises one raw PS/2 line, debounces it over FILTER_LEN equal samples, flags falling edges.
// Latency: 2 sync cycles + FILTER_LEN samples + 1 register before o_level/o_fall change.
// Backpressure: none; o_fall is a single-cycle pulse that must be consumed when asserted.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_fall;

  // Sync the async line, accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;  // idle PS/2 lines are pulled high
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;  // old level 1 -> new level 0
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data + parity, check device ACK.
// Latency: INHIBIT_CYCLES+1 before release, then paced by the device clock; one cycle after each filtered fall.
// Backpressure: wr_ps2 accepted only while tx_idle=1, ignored otherwise; ticks are unconditional 1-cycle pulses.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  logic w_c_lvl;
  logic w_c_fall;
  logic w_d_lvl;
  logic w_unused_d_fall;  // data-line falling edges have no consumer in the transmitter

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_line  (ps2c_in),
    .o_level (w_c_lvl),
    .o_fall  (w_c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_line  (ps2d_in),
    .o_level (w_d_lvl),
    .o_fall  (w_unused_d_fall)
  );

  ps2_state_t          r_state;
  logic [8:0]          r_shift;
  logic [EDGE_W-1:0]   r_n;
  logic [INH_W-1:0]    r_inh;
  logic [TO_W-1:0]     r_to;
  logic                r_c_oe;
  logic                r_d_oe;
  logic                r_idle;
  logic                r_done;
  logic                r_err;

  logic w_to_hit;
  assign w_to_hit = (r_to == TO_W'(TIMEOUT_CYCLES - 1));

  // Transmit FSM with all line drives and status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_n     <= '0;
      r_inh   <= '0;
      r_to    <= '0;
      r_c_oe  <= 1'b0;
      r_d_oe  <= 1'b0;
      r_idle  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_c_oe <= 1'b0;
          r_d_oe <= 1'b0;
          r_idle <= 1'b1;
          if (wr_ps2) begin
            r_shift <= ps2_frame(din);
            r_n     <= '0;
            r_inh   <= '0;
            r_c_oe  <= 1'b1;
            r_idle  <= 1'b0;
            r_state <= ST_RTS;
          end
        end
        ST_RTS: begin
          if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) begin
            r_d_oe  <= 1'b1;  // start bit goes out while the clock is still inhibited
            r_state <= ST_REQ;
          end else begin
            r_inh <= r_inh + INH_W'(1);
          end
        end
        ST_REQ: begin
          r_c_oe  <= 1'b0;
          r_to    <= '0;
          r_state <= ST_START;
        end
        ST_START, ST_DATA, ST_STOP, ST_ACKW: begin
          r_to <= w_c_fall ? '0 : r_to + TO_W'(1);
          if (!w_c_fall && w_to_hit) begin
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_err   <= 1'b1;
            r_idle  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            case (r_state)
              ST_START: begin
                if (w_c_fall) begin
                  r_d_oe  <= ~r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_n     <= EDGE_W'(1);
                  r_state <= ST_DATA;
                end
              end
              ST_DATA: begin
                if (w_c_fall) begin
                  if (r_n < EDGE_W'(9)) begin
                    r_d_oe  <= ~r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_n     <= r_n + EDGE_W'(1);
                  end else begin
                    r_d_oe  <= 1'b0;  // release for the stop bit
                    r_state <= ST_STOP;
                  end
                end
              end
              ST_STOP: begin
                if (w_c_fall) begin
                  if (!w_d_lvl) begin
                    r_state <= ST_ACKW;
                  end else begin
                    r_err   <= 1'b1;
                    r_idle  <= 1'b1;
                    r_state <= ST_IDLE;
                  end
                end
              end
              default: begin  // ST_ACKW: wait for the device to release both lines
                if (w_c_lvl && w_d_lvl) begin
                  r_done  <= 1'b1;
                  r_idle  <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
            endcase
          end
        end
        default: begin
          r_c_oe  <= 1'b0;
          r_d_oe  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2c_oe      = r_c_oe;
  assign ps2d_oe      = r_d_oe;
  assign tx_idle      = r_idle;
  assign tx_done_tick = r_done;
  assign tx_err_tick  = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on the open-drain lines, scoreboard queues for ticks and frames.
// Latency: shortened inhibit/timeout so every scenario fits a short run.
// Backpressure: n/a.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int FLT = 8;
  localparam int TOC = 2000;
  localparam int H   = 40;  // device half clock period in core cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b0;  // 1 = device pulls ps2c low
  logic       dev_d = 1'b0;  // 1 = device pulls ps2d low
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = ~(ps2c_oe | dev_c);
  assign ps2d_line = ~(ps2d_oe | dev_d);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TOC)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_line),
    .ps2d_in      (ps2d_line),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_err_cyc = 0;
  bit q_tick[$];          // expected tick kinds: 0 = done, 1 = err
  logic [9:0] q_frame[$]; // expected {stop, parity, data} as seen by the device

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ b[i];
    return {1'b1, p, b};
  endfunction

  // Tick monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge clk) begin
    if (reset && (tx_done_tick || tx_err_tick)) begin
      if (tx_err_tick) last_err_cyc = cyc;
      if (q_tick.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_tick: got done=%0b err=%0b expected none", tx_done_tick, tx_err_tick);
      end else begin
        check("tick_kind", {30'd0, tx_done_tick, tx_err_tick}, q_tick.pop_front() ? 32'd1 : 32'd2);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, clocks nedges falls, samples data on rises, optionally ACKs.
  task automatic dev_run(input bit ack, input int nedges, input int glitch_at, input int wr_at,
                         output logic [9:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(ps2c_line === 1'b1 && ps2d_line === 1'b0) && w < INH * 4) begin
      @(negedge clk);
      w++;
    end
    if (w >= INH * 4) begin
      n_chk++;
      n_err++;
      $display("FAIL dev_rts_wait: got no request-to-send within %0d cycles", INH * 4);
      return;
    end
    for (int k = 1; k <= nedges; k++) begin
      if (k == wr_at) begin
        @(negedge clk);
        din = 8'h55;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
      if (k == 11 && ack) dev_d = 1'b1;
      repeat (H) @(negedge clk);
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2d_line;
      dev_c = 1'b0;
      if (k == glitch_at) begin
        repeat (H / 2) @(negedge clk);
        dev_c = 1'b1;
        repeat (3) @(negedge clk);
        dev_c = 1'b0;
      end
    end
    if (nedges >= 11) begin
      repeat (H) @(negedge clk);
      dev_d = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (!(tx_idle && !ps2c_oe && !ps2d_oe) && w < 3 * TOC) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3 * TOC) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got busy after %0d cycles expected idle", name, w);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_test(input string name, input logic [7:0] b, input int glitch_at, input int wr_at);
    logic [9:0] got;
    q_tick.push_back(1'b0);
    q_frame.push_back(exp_frame(b));
    send(b);
    check({name, "_busy"}, {31'd0, tx_idle}, 32'd0);
    dev_run(1'b1, 11, glitch_at, wr_at, got);
    check({name, "_frame"}, {22'd0, got}, {22'd0, q_frame.pop_front()});
    wait_idle({name, "_idle"});
  endtask

  initial begin
    logic [9:0] got;
    int rts_len;
    int t_start;

    repeat (3) @(negedge clk);
    check("rst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("rst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    check("rst_idle", {31'd0, tx_idle}, 32'd1);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    check("rst_err",  {31'd0, tx_err_tick}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: measure inhibit length alongside the frame.
    rts_len = 0;
    fork
      frame_test("ed", CMD_SET_LEDS, 0, 0);
      begin
        int w;
        w = 0;
        while (!ps2c_oe && w < 100) begin @(negedge clk); w++; end
        while (ps2c_oe && rts_len < 4 * INH) begin @(negedge clk); rts_len++; end
      end
    join
    check_rng("rts_len", rts_len, INH, INH + 2);

    frame_test("x01", 8'h01, 0, 0);
    frame_test("x00", 8'h00, 0, 0);

    // Device withholds ACK.
    q_tick.push_back(1'b1);
    q_frame.push_back(exp_frame(8'h5A));
    send(8'h5A);
    dev_run(1'b0, 11, 0, 0, got);
    check("noack_frame", {22'd0, got}, {22'd0, q_frame.pop_front()});
    wait_idle("noack_idle");
    check("noack_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("noack_d_oe", {31'd0, ps2d_oe}, 32'd0);

    // Device never clocks.
    q_tick.push_back(1'b1);
    send(CMD_RESET);
    t_start = 0;
    begin
      int w;
      w = 0;
      while (ps2c_oe !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      w = 0;
      while (ps2c_oe && w < 4 * INH) begin @(negedge clk); w++; end
      t_start = cyc;
    end
    wait_idle("timeout_idle");
    check_rng("timeout_len", last_err_cyc - t_start, TOC - 2, TOC + 2);

    // Write request during DATA must be ignored; glitch must not count as an edge.
    frame_test("wr_ignored", 8'h3C, 0, 4);
    frame_test("glitch", 8'h96, 3, 0);

    // Reset asserted at the fifth device clock fall.
    send(8'h00);
    dev_run(1'b1, 4, 0, 0, got);
    repeat (H) @(negedge clk);
    dev_c = 1'b1;
    repeat (FLT + 4) @(negedge clk);
    check("pre_rst_d_oe", {31'd0, ps2d_oe}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    check("midrst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    check("midrst_idle", {31'd0, tx_idle}, 32'd1);
    @(negedge clk);
    dev_c = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    frame_test("recover", CMD_SCAN_SET, 0, 0);

    check("pending_ticks", q_tick.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1);
  end

endmodule
